// File: rtl/axis_lrelu_frame_tx_pkg.sv
// Shared constants and state encoding for the LReLU transmit framer.
// Field positions describe where kh2 lives inside the per-member tuser word.
package axis_lrelu_frame_tx_pkg;
   localparam int I_KH2         = 2;
   localparam int BITS_KH2      = 2;
   localparam int CFG_BEATS_1X1 = 2;
   localparam int CFG_BEATS_3X3 = 6;

   typedef enum logic [1:0] {
      CFG_FIRST_S = 2'd0,
      CFG_REST_S  = 2'd1,
      DATA_S      = 2'd2
   } state_t;
endpackage

// File: rtl/axis_skid_slice.sv
// Generic 2-entry skid buffer: 1-cycle latency, full throughput.
// wr_rdy is registered so the upstream never sees a path from rd_rdy.
module axis_skid_slice #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_vld,
   output logic             wr_rdy,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             rd_vld,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat
);
   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic [1:0]       count_nxt;
   logic             push;
   logic             pop;

   assign push   = wr_vld & wr_rdy;
   assign pop    = rd_vld & rd_rdy;
   assign rd_vld = (count != 2'd0);
   assign rd_dat = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + 2'd1;
      else if (!push && pop)
         count_nxt = count - 2'd1;
   end

   // Ready looks one cycle ahead so a full slice never accepts a third beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         wr_rdy <= 1'b0;
      end else begin
         count  <= count_nxt;
         wr_rdy <= (count_nxt != 2'd2);
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_dat;
   end
endmodule

// File: rtl/axis_lrelu_frame_tx.sv
// Frames each LReLU iteration as config beats followed by conv beats on one stream.
// Output goes through a 2-entry skid slice; input readies never depend on m_axis_tready.
module axis_lrelu_frame_tx #(
   parameter int DATA_WIDTH    = 32,
   parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
   parameter int TUSER_WIDTH   = 8,
   parameter int I_KH2         = axis_lrelu_frame_tx_pkg::I_KH2,
   parameter int BITS_KH2      = axis_lrelu_frame_tx_pkg::BITS_KH2,
   parameter int CFG_BEATS_1X1 = axis_lrelu_frame_tx_pkg::CFG_BEATS_1X1,
   parameter int CFG_BEATS_3X3 = axis_lrelu_frame_tx_pkg::CFG_BEATS_3X3
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   s_cfg_tvalid,
   output logic                   s_cfg_tready,
   input  logic [DATA_WIDTH-1:0]  s_cfg_tdata,
   input  logic [TUSER_WIDTH-1:0] s_cfg_tuser,
   input  logic                   s_cfg_tlast,
   input  logic                   s_conv_tvalid,
   output logic                   s_conv_tready,
   input  logic [DATA_WIDTH-1:0]  s_conv_tdata,
   input  logic [KEEP_WIDTH-1:0]  s_conv_tkeep,
   input  logic [TUSER_WIDTH-1:0] s_conv_tuser,
   input  logic                   s_conv_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0] m_axis_tuser,
   output logic                   m_axis_tlast,
   output logic                   err_cfg_len,
   output logic [15:0]            iter_count
);
   import axis_lrelu_frame_tx_pkg::*;

   localparam int PW = DATA_WIDTH + KEEP_WIDTH + TUSER_WIDTH + 1;
   localparam int RW = $clog2(CFG_BEATS_3X3 + 1);

   state_t                   state;
   state_t                   state_nxt;
   logic [RW-1:0]            remaining;
   logic [RW-1:0]            remaining_nxt;
   logic [BITS_KH2-1:0]      kh2;
   logic [BITS_KH2-1:0]      kh2_nxt;
   logic [BITS_KH2-1:0]      cfg_kh2;
   logic [RW-1:0]            first_rem;
   logic                     cfg_final;
   logic                     route_data;
   logic                     skid_rdy;
   logic                     cfg_hs;
   logic                     conv_hs;
   logic [TUSER_WIDTH-1:0]   cfg_user;
   logic [PW-1:0]            wr_dat;
   logic                     wr_vld;
   logic [PW-1:0]            rd_dat;

   assign route_data    = (state == DATA_S);
   assign s_cfg_tready  = skid_rdy & ~route_data;
   assign s_conv_tready = skid_rdy & route_data;
   assign cfg_hs        = s_cfg_tvalid & s_cfg_tready;
   assign conv_hs       = s_conv_tvalid & s_conv_tready;
   assign cfg_kh2       = s_cfg_tuser[I_KH2 +: BITS_KH2];
   assign first_rem     = (cfg_kh2 == '0) ? RW'(CFG_BEATS_1X1 - 1) : RW'(CFG_BEATS_3X3 - 1);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= CFG_FIRST_S;
         remaining <= '0;
         kh2       <= '0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         kh2       <= kh2_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      kh2_nxt       = kh2;
      cfg_final     = 1'b0;
      case (state)
         CFG_FIRST_S: begin
            cfg_final = (first_rem == '0);
            if (cfg_hs) begin
               kh2_nxt       = cfg_kh2;
               remaining_nxt = first_rem;
               state_nxt     = cfg_final ? DATA_S : CFG_REST_S;
            end
         end
         CFG_REST_S: begin
            cfg_final = (remaining == RW'(1));
            if (cfg_hs) begin
               remaining_nxt = remaining - RW'(1);
               if (cfg_final)
                  state_nxt = DATA_S;
            end
         end
         DATA_S: begin
            if (conv_hs && s_conv_tlast)
               state_nxt = CFG_FIRST_S;
         end
         default: state_nxt = CFG_FIRST_S;
      endcase
   end

   // The first config beat carries its own kh2; later beats are forced to agree with it.
   always_comb begin
      cfg_user = s_cfg_tuser;
      if (state == CFG_REST_S)
         cfg_user[I_KH2 +: BITS_KH2] = kh2;
      wr_vld = route_data ? s_conv_tvalid : s_cfg_tvalid;
      wr_dat = route_data ? {s_conv_tdata, s_conv_tkeep, s_conv_tuser, s_conv_tlast}
                          : {s_cfg_tdata, {KEEP_WIDTH{1'b1}}, cfg_user, 1'b0};
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_cfg_len <= 1'b0;
         iter_count  <= 16'd0;
      end else begin
         if (cfg_hs && (s_cfg_tlast != cfg_final))
            err_cfg_len <= 1'b1;
         if (conv_hs && s_conv_tlast)
            iter_count <= iter_count + 16'd1;
      end
   end

   axis_skid_slice #(.WIDTH(PW)) u_skid (
      .clk    (aclk),
      .rst_n  (aresetn),
      .wr_vld (wr_vld),
      .wr_rdy (skid_rdy),
      .wr_dat (wr_dat),
      .rd_vld (m_axis_tvalid),
      .rd_rdy (m_axis_tready),
      .rd_dat (rd_dat)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = rd_dat;
endmodule
